heap_access_controller: RTL and testbench

- Sequences every access to the single-port heapMemory block and shares it between several requesters, e.g. the instruction interpreter, the array allocator and the out-channel drain.
- Accepts array/index requests over valid/ready, translates them to heap addresses and generates the heapClock strobe protocol (setup, strobe, capture).
- Returns read data or write echo with an error flag.
- Replaces the hand-sequenced movRead1/movRead2/movWrite1/step instruction pairs.

---
 rtl/heap_pkg.sv | 33 +++
 rtl/heap_access_controller_if.sv | 43 ++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/heap_access_controller.sv | 158 +++++++++++++++
 tb/tb_heap_access_controller.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/heap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : heap_pkg
// Purpose  : Shared defaults, FSM state encoding and the heap address helper
//            for the heap access controller.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package heap_pkg;

  localparam int DefaultMemoryElementWidth = 12;
  localparam int DefaultNArea              = 4;
  localparam int DefaultNArrays            = 1;
  localparam int DefaultNHeap              = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    CAPTURE = 2'd2,
    ERROR   = 2'd3
  } state_e;

  // Linear heap address of an array element. Callers truncate the result to
  // the heap address width; bounds are checked separately so that the
  // truncation never aliases a legal access.
  function automatic logic [31:0] heap_addr(input logic [31:0] array,
                                            input logic [31:0] index,
                                            input logic [31:0] n_area);
    return array * n_area + index;
  endfunction

endpackage
`default_nettype wire

// File: rtl/heap_access_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : heap_access_controller_if
// Purpose  : Requester handshake, response and heapMemory bus bundle.
// Ports    : req_valid/req_ready/req_write/req_array/req_index/req_data
//            (requester slices, MemoryElementWidth each), resp_valid/
//            resp_data/resp_error, heapClock/heapWrite/heapAddress/heapIn/
//            heapOut. Modport slave = controller side, master = environment.
// Revision : 1.0  initial release
// ============================================================================
interface heap_access_controller_if #(
  parameter int NReq               = 2,
  parameter int MemoryElementWidth = 12,
  parameter int NHeap              = 4
);
  logic [NReq-1:0]                    req_valid;
  logic [NReq-1:0]                    req_ready;
  logic [NReq-1:0]                    req_write;
  logic [NReq*MemoryElementWidth-1:0] req_array;
  logic [NReq*MemoryElementWidth-1:0] req_index;
  logic [NReq*MemoryElementWidth-1:0] req_data;
  logic [NReq-1:0]                    resp_valid;
  logic [MemoryElementWidth-1:0]      resp_data;
  logic                               resp_error;
  logic                               heapClock;
  logic                               heapWrite;
  logic [NHeap-1:0]                   heapAddress;
  logic [MemoryElementWidth-1:0]      heapIn;
  logic [MemoryElementWidth-1:0]      heapOut;

  modport slave (
    input  req_valid, req_write, req_array, req_index, req_data, heapOut,
    output req_ready, resp_valid, resp_data, resp_error,
           heapClock, heapWrite, heapAddress, heapIn
  );

  modport master (
    output req_valid, req_write, req_array, req_index, req_data, heapOut,
    input  req_ready, resp_valid, resp_data, resp_error,
           heapClock, heapWrite, heapAddress, heapIn
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Grants the first requester
//            found scanning upward from ptr+1 with wrap-around.
// Ports    : req (request vector), ptr (last granted id), enable,
//            grant (one-hot or zero), grant_id (index of the grant).
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NReq = 2,
  localparam int IdW  = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic [NReq-1:0] req,
  input  logic [IdW-1:0]  ptr,
  input  logic            enable,
  output logic [NReq-1:0] grant,
  output logic [IdW-1:0]  grant_id
);

  always_comb begin
    logic found;
    int   idx;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    // Offset NReq wraps back to ptr itself, so a lone requester that was
    // served last is still granted again.
    for (int off = 1; off <= NReq; off++) begin
      idx = (int'(ptr) + off) % NReq;
      if (enable && !found && req[idx[IdW-1:0]]) begin
        found                = 1'b1;
        grant[idx[IdW-1:0]]  = 1'b1;
        grant_id             = idx[IdW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/heap_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : heap_access_controller
// Purpose  : Shares the single-port heapMemory among NReq requesters.
//            Translates array/index requests into heap addresses, drives the
//            heapClock setup/strobe/capture sequence and returns read data
//            (or the echoed write data) with a bounds error flag.
// Ports    : clock - rising-edge clock
//            reset - asynchronous active-low reset
//            bus   - slave modport: request handshake, response, heap bus
// Revision : 1.0  initial release
// ============================================================================
module heap_access_controller
  import heap_pkg::*;
#(
  parameter int NReq               = 2,
  parameter int MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int NArea              = DefaultNArea,
  parameter int NArrays            = DefaultNArrays,
  parameter int NHeap              = DefaultNHeap
) (
  input logic                      clock,
  input logic                      reset,
  heap_access_controller_if.slave  bus
);

  localparam int IdW   = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int W     = MemoryElementWidth;
  localparam int AddrW = W + ((NArea > 1) ? $clog2(NArea) : 1);

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  id_q, id_d;
  logic            heap_clock_q, heap_clock_d;
  logic            heap_write_q, heap_write_d;
  logic [NHeap-1:0] heap_addr_q, heap_addr_d;
  logic [W-1:0]    heap_in_q, heap_in_d;
  logic [NReq-1:0] resp_valid_q, resp_valid_d;
  logic [W-1:0]    resp_data_q, resp_data_d;
  logic            resp_error_q, resp_error_d;

  logic [NReq-1:0] grant;
  logic [IdW-1:0]  grant_id;
  logic            arb_en;
  logic [W-1:0]    sel_array;
  logic [W-1:0]    sel_index;
  logic [W-1:0]    sel_data;
  logic            sel_write;
  logic            sel_oob;

  // Gating with reset keeps req_ready low while reset is held, not only
  // after the first clock edge.
  assign arb_en = (state_q == IDLE) && reset;

  rr_arbiter #(.NReq(NReq)) u_arb (
    .req      (bus.req_valid),
    .ptr      (ptr_q),
    .enable   (arb_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.req_ready = grant;

  assign sel_array = bus.req_array[grant_id*W +: W];
  assign sel_index = bus.req_index[grant_id*W +: W];
  assign sel_data  = bus.req_data[grant_id*W +: W];
  assign sel_write = bus.req_write[grant_id];
  assign sel_oob   = (sel_index >= W'(NArea)) || (sel_array >= W'(NArrays));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    heap_clock_d = heap_clock_q;
    heap_write_d = heap_write_q;
    heap_addr_d  = heap_addr_q;
    heap_in_d    = heap_in_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          ptr_d = grant_id;
          id_d  = grant_id;
          if (sel_oob) begin
            state_d = ERROR;
          end else begin
            heap_addr_d  = NHeap'(AddrW'(heap_addr(32'(sel_array),
                                                   32'(sel_index),
                                                   32'(NArea))));
            heap_in_d    = sel_data;
            heap_write_d = sel_write;
            state_d      = STROBE;
          end
        end
      end
      STROBE: begin
        heap_clock_d = 1'b1;
        state_d      = CAPTURE;
      end
      CAPTURE: begin
        // For a write the memory drives heapOut with the just-written word,
        // so the same capture path echoes the write data.
        heap_clock_d         = 1'b0;
        resp_data_d          = bus.heapOut;
        resp_error_d         = 1'b0;
        resp_valid_d[id_q]   = 1'b1;
        state_d              = IDLE;
      end
      ERROR: begin
        resp_data_d          = '0;
        resp_error_d         = 1'b1;
        resp_valid_d[id_q]   = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= IdW'(NReq - 1);
      id_q         <= '0;
      heap_clock_q <= 1'b0;
      heap_write_q <= 1'b0;
      heap_addr_q  <= '0;
      heap_in_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      heap_clock_q <= heap_clock_d;
      heap_write_q <= heap_write_d;
      heap_addr_q  <= heap_addr_d;
      heap_in_q    <= heap_in_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign bus.heapClock   = heap_clock_q;
  assign bus.heapWrite   = heap_write_q;
  assign bus.heapAddress = heap_addr_q;
  assign bus.heapIn      = heap_in_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_error  = resp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_heap_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_heap_access_controller
// Purpose  : Self-checking bench for heap_access_controller with a heap
//            memory model, a shadow memory and a response scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_heap_access_controller;

  localparam int W  = 12;
  localparam int NR = 2;

  typedef struct {
    int id;
    int data;
    bit err;
    int acc;
  } exp_t;

  logic clk;
  logic reset_n;
  heap_access_controller_if #(.NReq(NR), .MemoryElementWidth(W), .NHeap(4)) bus();

  heap_access_controller dut (
    .clock (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   strobes = 0;
  int   last_addr = 0;
  int   last_rdata = 0;
  int   gcnt[NR];
  int   rcnt[NR];
  int   gid[$];
  int   gcyc[$];
  exp_t sb[$];
  logic [W-1:0] mem[16];
  int   shadow[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // heapMemory model: acts on the rising edge of heapClock.
  initial for (int i = 0; i < 16; i++) begin mem[i] = '0; shadow[i] = 0; end
  assign bus.heapOut = mem[bus.heapAddress];
  always @(posedge bus.heapClock) begin
    strobes++;
    last_addr = int'(bus.heapAddress);
    if (bus.heapWrite) mem[bus.heapAddress] <= bus.heapIn;
  end

  always @(posedge clk) cyc++;

  // Accept monitor pushes expectations; response monitor pops and compares.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.req_ready != '0) chk("ready_onehot", $countones(bus.req_ready), 1);
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i] && bus.req_valid[i]) begin
          exp_t e;
          int arr, idx, dat, addr;
          arr = int'(bus.req_array[i*W +: W]);
          idx = int'(bus.req_index[i*W +: W]);
          dat = int'(bus.req_data[i*W +: W]);
          e.id  = i;
          e.acc = cyc + 1;
          e.err = (idx >= 4) || (arr >= 1);
          addr  = (arr * 4 + idx) % 16;
          if (e.err) e.data = 0;
          else if (bus.req_write[i]) begin e.data = dat; shadow[addr] = dat; end
          else e.data = shadow[addr];
          sb.push_back(e);
          gcnt[i]++;
          gid.push_back(i);
          gcyc.push_back(e.acc);
        end
      end
      if (bus.resp_valid != '0) begin
        if (sb.size() == 0) chk("resp_unexpected", 32'(bus.resp_valid), 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          rcnt[e.id]++;
          last_rdata = int'(bus.resp_data);
          chk("resp_route", 32'(bus.resp_valid), 32'(1 << e.id));
          chk("resp_data", 32'(bus.resp_data), 32'(e.data));
          chk("resp_error", 32'(bus.resp_error), 32'(e.err));
          chk("resp_latency", 32'(cyc - e.acc), e.err ? 1 : 2);
        end
      end
    end
  end

  task automatic set_req(input int id, input bit wr, input int arr, input int idx, input int dat);
    bus.req_write[id]          = wr;
    bus.req_array[id*W +: W]   = W'(arr);
    bus.req_index[id*W +: W]   = W'(idx);
    bus.req_data[id*W +: W]    = W'(dat);
    bus.req_valid[id]          = 1'b1;
  endtask

  task automatic issue(input int id, input bit wr, input int arr, input int idx, input int dat);
    bit done;
    done = 1'b0;
    set_req(id, wr, arr, idx, dat);
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      chk("issue_timeout", 0, 1);
      bus.req_valid[id] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Holds current valids until n more grants were accepted, then drops all.
  task automatic serve(input int n);
    int base;
    base = gid.size();
    for (int k = 0; k < 80 && gid.size() < base + n; k++) @(negedge clk);
    if (gid.size() < base + n) chk("serve_timeout", gid.size() - base, n);
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, b0, g1, r1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_array = '0;
    bus.req_index = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NR; i++) begin gcnt[i] = 0; rcnt[i] = 0; end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_data", 32'(bus.resp_data), 0);
    chk("rst_resp_error", 32'(bus.resp_error), 0);
    chk("rst_heap_clock", 32'(bus.heapClock), 0);
    chk("rst_heap_addr", 32'(bus.heapAddress), 0);
    chk("rst_heap_in_wr", 32'({bus.heapIn, bus.heapWrite}), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back.
    s0 = strobes;
    issue(0, 1'b1, 0, 2, 3);
    drain();
    chk("wr_strobes", strobes - s0, 1);
    chk("wr_addr", last_addr, 2);
    chk("wr_echo", last_rdata, 3);
    s0 = strobes;
    issue(0, 1'b0, 0, 2, 0);
    drain();
    chk("rd_strobes", strobes - s0, 1);
    chk("rd_addr", last_addr, 2);
    chk("rd_data", last_rdata, 3);

    // Preload, last grant to requester 1, then contention.
    issue(0, 1'b1, 0, 0, 1); drain();
    issue(1, 1'b1, 0, 1, 2); drain();
    b0 = gid.size();
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 1, 0);
    serve(4);
    drain();
    for (int k = 0; k < 4; k++) begin
      if (gid.size() > b0 + k) chk("cont_order", gid[b0+k], k % 2);
      if (k > 0 && gcyc.size() > b0 + k) chk("cont_spacing", gcyc[b0+k] - gcyc[b0+k-1], 3);
    end

    // Bounds errors: no strobe, heap unchanged.
    s0 = strobes;
    issue(0, 1'b0, 0, 4, 0); drain();
    chk("oob_index_data", last_rdata, 0);
    issue(1, 1'b1, 1, 0, 7); drain();
    chk("oob_array_data", last_rdata, 0);
    chk("oob_strobes", strobes - s0, 0);
    begin
      int diff;
      diff = 0;
      for (int i = 0; i < 16; i++) if (int'(mem[i]) != shadow[i]) diff++;
      chk("oob_heap_intact", diff, 0);
    end

    // Loop replay: write 1,2,3 then read back and compare with 2.
    for (int k = 0; k < 3; k++) begin issue(0, 1'b1, 0, k, k + 1); drain(); end
    for (int k = 0; k < 3; k++) begin
      issue(0, 1'b0, 0, k, 0); drain();
      chk("loop_rd", last_rdata, k + 1);
      chk("loop_cmp2", 32'(last_rdata == 2), 32'(k == 1));
    end

    // Withdrawn request while busy.
    g1 = gcnt[1];
    r1 = rcnt[1];
    issue(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 1, 0);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("wd_grant1", gcnt[1] - g1, 0);
    chk("wd_resp1", rcnt[1] - r1, 0);

    // Reset during STROBE, requester 0 was last granted.
    issue(0, 1'b0, 0, 1, 0);
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 1, 0);
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_heap_clock", 32'(bus.heapClock), 0);
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_hold_clock", 32'(bus.heapClock), 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 1);
    b0 = gid.size();
    serve(2);
    drain();
    if (gid.size() > b0) chk("post_rst_first", gid[b0], 0);
    else chk("post_rst_first_missing", gid.size(), b0 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
